// File: rtl/measure_accumulator.sv
// Sample accumulator that drives an external two-cycle adder one request at a time.
// Each accepted sample is added to the running sum, and a sticky flag records any unsigned wrap.
module measure_accumulator #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [31:0]      sample_i,
  input  logic             sample_valid_i,
  output logic             sample_ready_o,
  output logic [31:0]      add_a_o,
  output logic [31:0]      add_b_o,
  output logic             add_valid_o,
  input  logic             add_valid_i,
  input  logic [31:0]      add_res_i,
  output logic [31:0]      sum_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);

  // IDLE: wait for start | ACCEPT: take one sample | WAIT_ADD: request in flight
  // SETTLE: adder high half resolving, load sum | DONE: one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, ACCEPT, WAIT_ADD, SETTLE, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [31:0]        sum_q, sum_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        add_a_q, add_a_d;
  logic [31:0]        add_b_q, add_b_d;
  logic               add_valid_q, add_valid_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      remain_q    <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_valid_q <= add_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          remain_d = count_i;
          sum_d    = '0;
          ovf_d    = 1'b0;
          state_d  = (count_i == '0) ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        if (sample_valid_i) begin
          add_a_d     = sum_q;
          add_b_d     = sample_i;
          add_valid_d = 1'b1;
          state_d     = WAIT_ADD;
        end
      end
      WAIT_ADD: begin
        if (add_valid_i) state_d = SETTLE;
      end
      SETTLE: begin
        // The result is only complete one cycle after add_valid_i, so it is captured here.
        sum_d    = add_res_i;
        ovf_d    = ovf_q | (add_res_i < sum_q);
        remain_d = remain_q - CNT_W'(1);
        state_d  = (remain_q == CNT_W'(1)) ? DONE : ACCEPT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sample_ready_o = (state_q == ACCEPT);
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign add_a_o        = add_a_q;
  assign add_b_o        = add_b_q;
  assign add_valid_o    = add_valid_q;
  assign sum_o          = sum_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_measure_accumulator.sv
// Directed bench for measure_accumulator with a behavioural two-cycle adder.
module tb_measure_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] count = '0;
  logic [31:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        ready;
  logic [31:0] add_a, add_b, add_res, sum;
  logic        add_valid_o, add_valid_i, ovf, busy, done;

  logic        v1 = 1'b0;
  logic [31:0] p1 = '0;
  int          n_addv = 0, n_done = 0;
  int          n_chk = 0, n_pass = 0;

  measure_accumulator #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .count_i(count),
    .sample_i(sample), .sample_valid_i(sample_valid), .sample_ready_o(ready),
    .add_a_o(add_a), .add_b_o(add_b), .add_valid_o(add_valid_o),
    .add_valid_i(add_valid_i), .add_res_i(add_res),
    .sum_o(sum), .overflow_o(ovf), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Adder: request seen at edge k+1, result valid k+2..k+3, result held afterwards.
  initial begin
    add_valid_i = 1'b0;
    add_res     = '0;
  end
  always @(posedge clk) begin
    v1          <= add_valid_o;
    p1          <= add_a + add_b;
    add_valid_i <= v1;
    if (v1) add_res <= p1;
  end

  always @(posedge clk) begin
    if (add_valid_o) n_addv <= n_addv + 1;
    if (done) n_done <= n_done + 1;
  end

  typedef struct {
    logic [15:0]      cnt;
    logic [3:0][31:0] s;
    int               gap;
    logic             poke;
    logic [31:0]      exp_sum;
    logic             exp_ovf;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] c, input logic [31:0] s0, s1, s2, s3,
                              input int gap, input logic poke,
                              input logic [31:0] es, input logic eo);
    vec_t v;
    v.cnt = c; v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
    v.gap = gap; v.poke = poke; v.exp_sum = es; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic run_vec(input vec_t v);
    int          waits;
    int          a0, d0;
    logic [31:0] part;
    a0 = n_addv;
    d0 = n_done;
    start = 1'b1; count = v.cnt; sample = v.s[0]; sample_valid = (v.gap == 0);
    @(negedge clk);
    count = 16'hFFFF;
    start = v.poke;
    chk("start_clear_sum", sum, 32'd0);
    chk("start_clear_ovf", 32'(ovf), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    part = '0;
    for (int i = 0; i < int'(v.cnt); i++) begin
      for (int j = 0; j < v.gap; j++) begin
        chk("ready_while_waiting", 32'(ready), 32'd1);
        @(negedge clk);
      end
      sample = v.s[i]; sample_valid = 1'b1;
      chk("ready_before_xfer", 32'(ready), 32'd1);
      @(negedge clk);
      chk("add_b", add_b, v.s[i]);
      chk("add_a", add_a, part);
      chk("add_valid_pulse", 32'(add_valid_o), 32'd1);
      part = part + v.s[i];
      sample_valid = (v.gap == 0) && (i + 1 < int'(v.cnt));
      if (i + 1 < int'(v.cnt)) sample = v.s[i+1];
      waits = 0;
      while (!ready && !done && waits < 20) begin
        @(negedge clk);
        waits++;
      end
      chk("xfer_spacing", 32'(waits), 32'd4);
      chk("partial_sum", sum, part);
    end
    chk("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("done_single", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("final_sum", sum, v.exp_sum);
    chk("final_ovf", 32'(ovf), 32'(v.exp_ovf));
    chk("add_req_count", 32'(n_addv - a0), 32'(v.cnt));
    chk("done_count", 32'(n_done - d0), 32'd1);
    repeat (3) @(negedge clk);
    chk("sum_hold", sum, v.exp_sum);
    chk("ovf_hold", 32'(ovf), 32'(v.exp_ovf));
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(16'd3, 32'd10, 32'd20, 32'd30, 32'd0, 0, 1'b0, 32'd60, 1'b0);
    vecs[1] = mk(16'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 32'd0, 1'b0);
    vecs[2] = mk(16'd2, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 0, 1'b0, 32'h10, 1'b1);
    vecs[3] = mk(16'd2, 32'd100, 32'd200, 32'd0, 32'd0, 7, 1'b0, 32'd300, 1'b0);
    vecs[4] = mk(16'd3, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 0, 1'b0, 32'd2, 1'b1);
    vecs[5] = mk(16'd2, 32'd3, 32'd4, 32'd0, 32'd0, 0, 1'b1, 32'd7, 1'b0);
    vecs[6] = mk(16'd4, 32'd1, 32'd2, 32'd3, 32'd4, 0, 1'b0, 32'd10, 1'b0);

    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_add_valid", 32'(add_valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Abandon a count=4 run in WAIT_ADD; the adder's late valid must not revive it.
    start = 1'b1; count = 16'd4; sample = 32'd7; sample_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("pre_rst_add_b", add_b, 32'd7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_add_a", add_a, 32'd0);
    chk("mid_rst_add_b", add_b, 32'd0);
    chk("mid_rst_add_valid", 32'(add_valid_o), 32'd0);
    chk("mid_rst_sum", sum, 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("late_add_ignored_busy", 32'(busy), 32'd0);
      chk("late_add_ignored_sum", sum, 32'd0);
    end
    run_vec(mk(16'd1, 32'd5, 32'd0, 32'd0, 32'd0, 0, 1'b0, 32'd5, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/measure_accumulator.md
MEASURE_ACCUMULATOR -- requirements
Module: measure_accumulator

Interface
REQ-001 Parameter CNT_W, default 16, width of sample-count input and internal remaining-sample counter.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 start_i  in  1  begin accumulation run; honoured only in IDLE.
REQ-005 count_i  in  CNT_W  number of samples in run; latched on accepted start_i.
REQ-006 sample_i  in  32  unsigned measurement sample.
REQ-007 sample_valid_i  in  1  sample_i valid.
REQ-008 sample_ready_o  out  1  block accepts sample; transfer = sample_valid_i & sample_ready_o.
REQ-009 add_a_o  out  32  adder operand A (running sum), registered.
REQ-010 add_b_o  out  32  adder operand B (accepted sample), registered.
REQ-011 add_valid_o  out  1  adder request, registered, one-cycle pulse.
REQ-012 add_valid_i  in  1  adder result-valid from two-cycle adder.
REQ-013 add_res_i  in  32  adder result.
REQ-014 sum_o  out  32  running/final sum; held between runs.
REQ-015 overflow_o  out  1  sticky unsigned wrap flag for current run.
REQ-016 busy_o  out  1  high in any state except IDLE.
REQ-017 done_o  out  1  one-cycle pulse at run completion.

Function
REQ-018 FSM states SHALL be IDLE, ACCEPT, WAIT_ADD, SETTLE, DONE.
REQ-019 IDLE: on start_i, latch count_i into remain, clear sum_o and overflow_o; go DONE if count_i==0, else ACCEPT.
REQ-020 ACCEPT: sample_ready_o=1 (combinational from state); on transfer, add_a_o<=sum_o, add_b_o<=sample_i, add_valid_o<=1 for exactly one cycle, go WAIT_ADD.
REQ-021 sample_ready_o SHALL be 0 in every state except ACCEPT; at most one adder request in flight.
REQ-022 WAIT_ADD: on add_valid_i go SETTLE; otherwise stay (no timeout).
REQ-023 SETTLE: adder high half completes one cycle after add_valid_i, so sum_o SHALL be loaded from add_res_i at end of SETTLE, never in the add_valid_i cycle.
REQ-024 SETTLE: overflow_o <= overflow_o | (add_res_i < sum_o); remain <= remain-1; go DONE if remain==1, else ACCEPT.
REQ-025 DONE: done_o=1 for that cycle only, go IDLE; sum_o and overflow_o hold until next accepted start_i.
REQ-026 Arithmetic unsigned modulo 2^32; sum_o never saturates.
REQ-027 Timing: transfer at edge k -> add_valid_o high k..k+1, add_valid_i expected high k+2..k+3, SETTLE k+3..k+4, sum_o updated at edge k+4, sample_ready_o high again after k+4 (max throughput one sample per 5 cycles).
REQ-028 start_i outside IDLE SHALL be ignored, including the DONE cycle.
REQ-029 start_i and sample_valid_i in same IDLE cycle: sample not accepted.
REQ-030 add_a_o/add_b_o SHALL hold their values except on a transfer.
REQ-031 count_i changes after start SHALL not affect the run.

Reset
REQ-032 On rst_i high, immediately: state IDLE, sum_o=0, overflow_o=0, add_a_o=0, add_b_o=0, add_valid_o=0, done_o=0, busy_o=0, sample_ready_o=0, remain=0.
REQ-033 Reset mid-run SHALL abandon the run; any subsequent add_valid_i in IDLE SHALL be ignored.

Verification
REQ-034 count=3, samples 10,20,30 with sample_valid_i always high -> add_b_o 10,20,30; sum_o 10,30,60; done_o single pulse; overflow_o=0; transfers exactly 5 cycles apart.
REQ-035 count=0 -> busy_o one cycle, done_o pulse on cycle after start, sum_o=0, no add_valid_o.
REQ-036 count=2, samples 0xFFFFFFF0 then 0x20 -> sum_o=0x00000010, overflow_o=1 held after done until next start.
REQ-037 count=2, sample_valid_i delayed 7 cycles between samples -> sample_ready_o stays high while waiting, sum correct, no extra add_valid_o.
REQ-038 rst_i asserted in WAIT_ADD of count=4 run -> all outputs at reset values same cycle; late add_valid_i ignored; new start with count=1, sample 5 -> sum_o=5.
REQ-039 start_i pulsed in ACCEPT and DONE with different count_i -> ignored; run length and sum unchanged.
